load_store_unit: RTL and testbench

Sits between the execute stage and the byte-addressed, little-endian data memory, which has a word-wide port with a combinational read and a clocked whole-word write. Converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned memory accesses.
- Loads: extracts and sign- or zero-extends the addressed bytes.
- Sub-word stores: implemented as a two-cycle read-merge-write, because the memory only writes whole words.
- Misaligned or illegal requests: flagged, and no memory write is issued.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 136 +++++++++++++
 tb/tb_load_store_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared types, widths and request-checking helpers for the LSU.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

   typedef enum logic [2:0] {
      F3_BYTE  = 3'b000,
      F3_HALF  = 3'b001,
      F3_WORD  = 3'b010,
      F3_BYTEU = 3'b100,
      F3_HALFU = 3'b101
   } funct3_e;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      MERGE = 1'b1
   } state_e;

   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;

   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      if (is_store)
         return (f3 == F3_BYTE) || (f3 == F3_HALF) || (f3 == F3_WORD);
      return (f3 == F3_BYTE) || (f3 == F3_HALF) || (f3 == F3_WORD) ||
             (f3 == F3_BYTEU) || (f3 == F3_HALFU);
   endfunction

   function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] offset);
      case (f3[1:0])
         2'b01:   return ~offset[0];
         2'b10:   return offset == 2'b00;
         default: return 1'b1;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational sub-word extract/extend (i_merge=0) or merge (i_merge=1).
// Revision : 1.0
// ============================================================================
module lsu_align
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_merge,
   input  logic [WIDTH-1:0] i_word,
   input  logic [1:0]       i_offset,
   input  logic [2:0]       i_funct3,
   input  logic [WIDTH-1:0] i_store_data,
   output logic [WIDTH-1:0] o_result
);

   logic [4:0]       w_shamt;
   logic [WIDTH-1:0] w_shifted;
   logic [WIDTH-1:0] w_mask;
   logic [WIDTH-1:0] w_ins;

   always_comb begin
      w_shamt   = (i_funct3[1:0] == 2'b01) ? {i_offset[1], 4'b0000} : {i_offset, 3'b000};
      w_shifted = i_word >> w_shamt;
      w_mask    = '0;
      w_ins     = '0;
      o_result  = '0;

      case (i_funct3[1:0])
         2'b00: begin
            w_mask = {{(WIDTH-BYTE_W){1'b0}}, {BYTE_W{1'b1}}} << w_shamt;
            w_ins  = {{(WIDTH-BYTE_W){1'b0}}, i_store_data[BYTE_W-1:0]} << w_shamt;
         end
         2'b01: begin
            w_mask = {{(WIDTH-HALF_W){1'b0}}, {HALF_W{1'b1}}} << w_shamt;
            w_ins  = {{(WIDTH-HALF_W){1'b0}}, i_store_data[HALF_W-1:0]} << w_shamt;
         end
         default: begin
            w_mask = '1;
            w_ins  = i_store_data;
         end
      endcase

      if (i_merge) begin
         o_result = (i_word & ~w_mask) | (w_ins & w_mask);
      end else begin
         // Funct3[2] set means the unsigned variant, so the fill bit is forced to 0.
         case (i_funct3[1:0])
            2'b00:   o_result = {{(WIDTH-BYTE_W){w_shifted[BYTE_W-1] & ~i_funct3[2]}},
                                 w_shifted[BYTE_W-1:0]};
            2'b01:   o_result = {{(WIDTH-HALF_W){w_shifted[HALF_W-1] & ~i_funct3[2]}},
                                 w_shifted[HALF_W-1:0]};
            default: o_result = i_word;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32I load/store to word-wide memory; sub-word stores read-merge-write.
// Revision : 1.0
// ============================================================================
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ReqValid,
   input  logic             ReqWrite,
   input  logic [2:0]       Funct3,
   input  logic [WIDTH-1:0] Addr,
   input  logic [WIDTH-1:0] StoreData,
   output logic             Ready,
   output logic             RespValid,
   output logic             RespErr,
   output logic [WIDTH-1:0] LoadData,
   output logic [WIDTH-1:0] MemA,
   output logic [WIDTH-1:0] MemWD,
   output logic             MemWE,
   input  logic [WIDTH-1:0] MemRD
);

   state_e           r_state;
   state_e           w_next_state;
   logic             w_accept;
   logic             w_err;
   logic             w_sub_store;
   logic             w_load_ok;
   logic [WIDTH-1:0] w_aligned_addr;
   logic [WIDTH-1:0] w_load_ext;
   logic [WIDTH-1:0] w_merged;

   logic [WIDTH-1:0] r_addr;
   logic [WIDTH-1:0] r_word;
   logic [WIDTH-1:0] r_sd;
   logic [1:0]       r_off;
   logic [2:0]       r_f3;
   logic             r_resp_valid;
   logic             r_resp_err;
   logic [WIDTH-1:0] r_load_data;

   assign w_aligned_addr = {Addr[WIDTH-1:2], 2'b00};
   assign w_err          = !f3_legal(ReqWrite, Funct3) || !f3_aligned(Funct3, Addr[1:0]);
   assign w_accept       = ReqValid && (r_state == IDLE) && !RST;
   assign w_sub_store    = w_accept && !w_err && ReqWrite && (Funct3 != F3_WORD);
   assign w_load_ok      = w_accept && !w_err && !ReqWrite;

   assign Ready     = (r_state == IDLE);
   assign RespValid = r_resp_valid;
   assign RespErr   = r_resp_err;
   assign LoadData  = r_load_data;

   lsu_align #(.WIDTH(WIDTH)) u_load_align (
      .i_merge      (1'b0),
      .i_word       (MemRD),
      .i_offset     (Addr[1:0]),
      .i_funct3     (Funct3),
      .i_store_data (StoreData),
      .o_result     (w_load_ext)
   );

   lsu_align #(.WIDTH(WIDTH)) u_merge_align (
      .i_merge      (1'b1),
      .i_word       (r_word),
      .i_offset     (r_off),
      .i_funct3     (r_f3),
      .i_store_data (r_sd),
      .o_result     (w_merged)
   );

   always_ff @(posedge CLK) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      MemA         = '0;
      MemWD        = '0;
      MemWE        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept && !w_err) begin
               MemA = w_aligned_addr;
               if (ReqWrite && (Funct3 == F3_WORD)) begin
                  MemWD = StoreData;
                  MemWE = 1'b1;
               end
               if (w_sub_store) w_next_state = MERGE;
            end
         end
         MERGE: begin
            w_next_state = IDLE;
            // A reset landing on the merge cycle drops the pending write.
            if (!RST) begin
               MemA  = r_addr;
               MemWD = w_merged;
               MemWE = 1'b1;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_load_data  <= '0;
         r_addr       <= '0;
         r_word       <= '0;
         r_sd         <= '0;
         r_off        <= '0;
         r_f3         <= '0;
      end else begin
         r_resp_valid <= (w_accept && !w_sub_store) || (r_state == MERGE);
         r_resp_err   <= w_accept && w_err;
         r_load_data  <= w_load_ok ? w_load_ext : '0;
         if (w_sub_store) begin
            r_addr <= w_aligned_addr;
            r_word <= MemRD;
            r_sd   <= StoreData;
            r_off  <= Addr[1:0];
            r_f3   <= Funct3;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Self-checking bench: vector table, corner sequences, random vs byte model.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        ReqValid = 1'b0;
   logic        ReqWrite = 1'b0;
   logic [2:0]  Funct3 = 3'd0;
   logic [31:0] Addr = 32'd0;
   logic [31:0] StoreData = 32'd0;
   logic        Ready, RespValid, RespErr, MemWE;
   logic [31:0] LoadData, MemA, MemWD, MemRD;

   logic [31:0] mem [0:15];
   logic        mem_clear = 1'b1;
   logic [7:0]  ref_mem [0:63];
   int          we_count = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 CLK = ~CLK;

   load_store_unit #(.WIDTH(32)) dut (
      .CLK(CLK), .RST(RST), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
      .Funct3(Funct3), .Addr(Addr), .StoreData(StoreData), .Ready(Ready),
      .RespValid(RespValid), .RespErr(RespErr), .LoadData(LoadData),
      .MemA(MemA), .MemWD(MemWD), .MemWE(MemWE), .MemRD(MemRD)
   );

   // Word memory covering 0x10000..0x1003F (upper address bits alias).
   assign MemRD = mem[MemA[5:2]];
   always @(posedge CLK) begin
      if (mem_clear) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      end else if (MemWE) begin
         mem[MemA[5:2]] <= MemWD;
         we_count <= we_count + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model over a byte array ----------------
   function automatic bit m_err(input bit w, input logic [2:0] f3, input logic [31:0] a);
      bit legal;
      int size;
      legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size  = 1 << f3[1:0];
      return !legal || ((a % size) != 0);
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
      int     size;
      longint v;
      size = 1 << f3[1:0];
      v    = 0;
      for (int i = 0; i < size; i++) v = v | (longint'(ref_mem[(int'(a[5:0]) + i) % 64]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8 * size));
      return v[31:0];
   endfunction

   task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
      int size;
      size = 1 << f3[1:0];
      for (int i = 0; i < size; i++) ref_mem[(int'(a[5:0]) + i) % 64] = sd[8*i +: 8];
   endtask

   function automatic logic [31:0] m_word(input int idx);
      return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
   endfunction

   task automatic check_mem(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem[i] !== m_word(i)) bad++;
      check(name, bad, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, Ready, 1);
      check({tag, "_respvalid"}, RespValid, 0);
      check({tag, "_resperr"}, RespErr, 0);
      check({tag, "_loaddata"}, LoadData, 0);
      check({tag, "_memwe"}, MemWE, 0);
      check({tag, "_mema"}, MemA, 0);
      check({tag, "_memwd"}, MemWD, 0);
   endtask

   // One request through its full handshake; entry/exit a couple of ns after a rising edge.
   task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input bit exp_err, input logic [31:0] exp_ld);
      bit sub, sw;
      sub = !exp_err && w && (f3 != 3'd2);
      sw  = !exp_err && w && (f3 == 3'd2);
      ReqValid = 1'b1; ReqWrite = w; Funct3 = f3; Addr = a; StoreData = sd;
      #1;
      check("ready_accept", Ready, 1);
      check("we_accept", MemWE, sw);
      if (!exp_err) check("mema_accept", MemA, {a[31:2], 2'b00});
      if (sw) check("memwd_sw", MemWD, sd);
      tick();
      if (sub) begin
         m_store(f3, a, sd);
         // A competing load during the merge cycle must be ignored.
         ReqValid = 1'b1; ReqWrite = 1'b0; Funct3 = 3'd2; Addr = {a[31:2], 2'b00} ^ 32'h4;
         #1;
         check("ready_merge", Ready, 0);
         check("we_merge", MemWE, 1);
         check("mema_merge", MemA, {a[31:2], 2'b00});
         check("memwd_merge", MemWD, m_word(int'(a[5:2])));
         check("resp_early", RespValid, 0);
         tick();
         ReqValid = 1'b0;
         #1;
         check("ready_after_merge", Ready, 1);
      end else begin
         ReqValid = 1'b0;
         if (sw) m_store(f3, a, sd);
         #1;
      end
      check("resp_valid", RespValid, 1);
      check("resp_err", RespErr, exp_err);
      if (exp_err || !w) check("load_data", LoadData, exp_err ? 32'd0 : exp_ld);
      check("we_idle", MemWE, 0);
   endtask

   typedef struct {
      bit          w;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] sd;
      bit          err;
      logic [31:0] ld;
   } vec_t;

   vec_t        vecs [12];
   logic [31:0] bb_exp [4];
   int          we0;
   bit          rw, rerr;
   logic [2:0]  rf3;
   logic [31:0] ra, rsd, rld;

   initial begin
      vecs[0]  = '{0, 3'd0, 32'h10001, 32'h0, 0, 32'hFFFFFFAA};
      vecs[1]  = '{0, 3'd4, 32'h10001, 32'h0, 0, 32'h000000AA};
      vecs[2]  = '{0, 3'd1, 32'h10002, 32'h0, 0, 32'hFFFF8899};
      vecs[3]  = '{0, 3'd5, 32'h10002, 32'h0, 0, 32'h00008899};
      vecs[4]  = '{0, 3'd2, 32'h10000, 32'h0, 0, 32'h8899AABB};
      vecs[5]  = '{0, 3'd0, 32'h10003, 32'h0, 0, 32'hFFFFFF88};
      vecs[6]  = '{0, 3'd5, 32'h10000, 32'h0, 0, 32'h0000AABB};
      vecs[7]  = '{0, 3'd2, 32'h10002, 32'h0, 1, 32'h0};
      vecs[8]  = '{1, 3'd1, 32'h10001, 32'h1234, 1, 32'h0};
      vecs[9]  = '{0, 3'd3, 32'h10000, 32'h0, 1, 32'h0};
      vecs[10] = '{1, 3'd3, 32'h10000, 32'h55, 1, 32'h0};
      vecs[11] = '{0, 3'd1, 32'h10003, 32'h0, 1, 32'h0};
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;

      // Reset state
      repeat (2) tick();
      RST = 1'b0; mem_clear = 1'b0;
      #1;
      check_reset_outputs("reset");

      do_req(1, 3'd2, 32'h10000, 32'h8899AABB, 0, 32'h0);

      // Table: loads with extension, plus misaligned/illegal requests
      we0 = we_count;
      foreach (vecs[i]) do_req(vecs[i].w, vecs[i].f3, vecs[i].a, vecs[i].sd, vecs[i].err, vecs[i].ld);
      check("table_no_write", we_count, we0);
      check_mem("table_mem");

      // SB read-merge-write, then read back
      we0 = we_count;
      do_req(1, 3'd0, 32'h10002, 32'h0000005A, 0, 32'h0);
      check("sb_one_pulse", we_count, we0 + 1);
      check("sb_word", mem[0], 32'h885AAABB);
      do_req(0, 3'd2, 32'h10000, 32'h0, 0, 32'h885AAABB);

      // SW and read back, plus neighbours for the streaming test
      do_req(1, 3'd2, 32'h10004, 32'hDEADBEEF, 0, 32'h0);
      do_req(0, 3'd2, 32'h10004, 32'h0, 0, 32'hDEADBEEF);
      do_req(1, 3'd2, 32'h10008, 32'h01234567, 0, 32'h0);
      do_req(1, 3'd2, 32'h1000C, 32'hCAFEF00D, 0, 32'h0);

      // SH with reset landing in the merge cycle
      we0 = we_count;
      ReqValid = 1'b1; ReqWrite = 1'b1; Funct3 = 3'd1; Addr = 32'h10000; StoreData = 32'h1234;
      tick();
      ReqValid = 1'b0; RST = 1'b1;
      #1;
      check("rst_merge_we", MemWE, 0);
      tick();
      RST = 1'b0;
      #1;
      check_reset_outputs("rst_merge");
      check("rst_merge_no_write", we_count, we0);
      check("rst_merge_word", mem[0], 32'h885AAABB);
      check_mem("rst_merge_mem");

      // Back-to-back word loads
      bb_exp[0] = 32'h885AAABB; bb_exp[1] = 32'hDEADBEEF;
      bb_exp[2] = 32'h01234567; bb_exp[3] = 32'hCAFEF00D;
      for (int i = 0; i < 4; i++) begin
         ReqValid = 1'b1; ReqWrite = 1'b0; Funct3 = 3'd2; Addr = 32'h10000 + 32'(4 * i);
         #1;
         check("b2b_ready", Ready, 1);
         tick();
         check("b2b_valid", RespValid, 1);
         check("b2b_data", LoadData, bb_exp[i]);
      end
      ReqValid = 1'b0;
      #1;

      // Randomized traffic against the byte model
      for (int n = 0; n < 200; n++) begin
         rw   = bit'($urandom_range(0, 1));
         rf3  = 3'($urandom_range(0, 7));
         ra   = 32'h10000 + 32'($urandom_range(0, 63));
         rsd  = $urandom;
         rerr = m_err(rw, rf3, ra);
         rld  = (!rw && !rerr) ? m_load(rf3, ra) : 32'h0;
         do_req(rw, rf3, ra, rsd, rerr, rld);
         if ($urandom_range(0, 3) == 0) tick();
      end
      check_mem("random_mem");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
